// File: rtl/if_id_skid_reg_if.sv
// IF/ID handshake bundle: fetch-side beat in, decode-side beat out, plus branch flush.
interface if_id_skid_reg_if #(
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic [DATA_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              if_ready;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_instr;
    logic              id_ready;

    modport master (
        output if_valid, if_pc, if_instr, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_instr
    );

    modport slave (
        input  if_valid, if_pc, if_instr, flush, id_ready,
        output if_ready, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and branch flush.
// Optional IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_id_skid_reg_if.slave  bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_pc, main_instr;
    logic [DATA_W-1:0] skid_pc, skid_instr;
    logic [1:0]        state;
    logic              accept, xfer;

    // Occupancy is read straight off the valid bits; skid only fills behind main.
    assign state  = {skid_v, main_v};
    assign accept = bus.if_valid && !skid_v;
    assign xfer   = main_v && bus.id_ready;

    assign bus.if_ready = !skid_v;
    assign bus.id_valid = main_v;
    assign bus.id_pc    = main_pc;
    assign bus.id_instr = main_v ? main_instr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (bus.flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_v     <= 1'b1;
                        main_pc    <= bus.if_pc;
                        main_instr <= bus.if_instr;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_pc    <= bus.if_pc;
                        main_instr <= bus.if_instr;
                    end else if (accept) begin
                        skid_v     <= 1'b1;
                        skid_pc    <= bus.if_pc;
                        skid_instr <= bus.if_instr;
                    end else if (xfer) begin
                        main_v <= 1'b0;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        skid_v     <= 1'b0;
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_v && !bus.id_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            // Only flushes that actually squash something are counted.
            if (bus.flush && (main_v || skid_v) && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed steps then random traffic against a queue model.
module tb_if_id_skid_reg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    beat_t q[$];
    int    exp_stall = 0;
    int    exp_flush = 0;

    if_id_skid_reg_if #(.DATA_W(DATA_W)) bus ();

`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    if_id_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DATA_W-1:0] e_instr;
        e_instr = (q.size() > 0) ? q[0].instr : '0;
        chk({tag, "/if_ready"}, 64'(bus.if_ready), 64'(q.size() < 2));
        chk({tag, "/id_valid"}, 64'(bus.id_valid), 64'(q.size() > 0));
        chk({tag, "/id_instr"}, 64'(bus.id_instr), 64'(e_instr));
        if (q.size() > 0)
            chk({tag, "/id_pc"}, 64'(bus.id_pc), 64'(q[0].pc));
`ifdef IF_ID_PERF_EN
        chk({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
        chk({tag, "/flush_cnt"}, 64'(flush_cnt), 64'(exp_flush));
`endif
    endtask

    // Check current outputs, advance the model by one edge, then step past the edge.
    task automatic cycle(input string tag);
        bit consumed, accepted;
        check_outputs(tag);
        consumed = (q.size() > 0) && bus.id_ready;
        accepted = bus.if_valid && (q.size() < 2);
        if (q.size() > 0 && !bus.id_ready && exp_stall < 65535) exp_stall++;
        if (bus.flush && q.size() > 0 && exp_flush < 65535) exp_flush++;
        if (bus.flush) q.delete();
        else begin
            if (consumed) void'(q.pop_front());
            if (accepted) q.push_back('{pc: bus.if_pc, instr: bus.if_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [DATA_W-1:0] pc);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = $urandom;
    endtask

    initial begin
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_instr = '0;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;

        // Reset held across several edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst/id_pc", 64'(bus.id_pc), 64'd0);
        check_outputs("rst");
        rst = 1'b1;
        cycle("idle0");
        check_outputs("idle1");

        // Streaming
        bus.id_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            offer(1'b1, DATA_W'(4 * k));
            cycle("stream");
        end
        offer(1'b0, '0);
        cycle("stream_drain");
        cycle("stream_empty");

        // Stall into skid, then drain
        bus.id_ready = 1'b0;
        offer(1'b1, 32'd4);  cycle("stall_a");
        offer(1'b1, 32'd8);  cycle("stall_b");
        offer(1'b0, '0);     cycle("stall_full");
        chk("full/id_pc", 64'(bus.id_pc), 64'd4);
        bus.id_ready = 1'b1;
        cycle("drain_a");
        cycle("drain_b");
        cycle("drain_done");

        // Flush while FULL with a beat offered
        bus.id_ready = 1'b0;
        offer(1'b1, 32'd4);  cycle("refill_a");
        offer(1'b1, 32'd8);  cycle("refill_b");
        offer(1'b1, 32'd12);
        bus.flush = 1'b1;    cycle("flush_full");
        bus.flush = 1'b0;
        offer(1'b0, '0);
        chk("post_flush/id_valid", 64'(bus.id_valid), 64'd0);
        cycle("post_flush");

        // Flush with nothing held
        bus.flush = 1'b1;    cycle("flush_empty");
        bus.flush = 1'b0;    cycle("post_flush_empty");

        // Async reset mid-stall
        offer(1'b1, 32'd20); cycle("ar_a");
        offer(1'b1, 32'd24); cycle("ar_b");
        offer(1'b0, '0);
        check_outputs("ar_full");
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        exp_stall = 0;
        exp_flush = 0;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("ar_resume");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            offer(1'($urandom_range(0, 2) != 0), DATA_W'($urandom));
            bus.id_ready = ($urandom_range(0, 9) < 6);
            bus.flush    = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b1;
        cycle("final_a");
        cycle("final_b");
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
